// File: rtl/mau_pkg.sv
// mau_pkg
//    Shared types and helpers for the load/store initiator.
//    state_t    : control FSM states (IDLE, ACCESS, RESP)
//    size_t     : access size encoding (byte, half, word)
//    size_mask  : byte-lane mask for an aligned access of a given size
//    misaligned : fault predicate (illegal size or unaligned address)
package mau_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_t;

   function automatic logic [3:0] size_mask(size_t size);
      case (size)
         SZ_B:    return 4'h1;
         SZ_H:    return 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   // Takes the raw 2-bit size so the illegal encoding 3 can be flagged too.
   function automatic logic misaligned(logic [1:0] size, logic [1:0] offset);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return offset[0];
         2'd2:    return offset != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//    Request, response and memory-port signals of the load/store initiator.
//    slave  : the unit itself (takes requests, drives memory port)
//    master : the environment (execute stage + memory model)
interface mem_access_unit_if #(parameter int XLEN = 32);

   // request channel
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_addr;
   logic [XLEN-1:0] in_wdata;
   logic            in_wen;
   logic [1:0]      in_size;
   logic            in_unsigned;
   // response channel
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_rdata;
   logic            out_fault;
   // memory port
   logic            mem_valid;
   logic [XLEN-1:0] mem_raddr;
   logic            mem_wen;
   logic [XLEN-1:0] mem_waddr;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wmask;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  in_valid, in_addr, in_wdata, in_wen, in_size, in_unsigned,
      input  out_ready, mem_rdata,
      output in_ready, out_valid, out_rdata, out_fault,
      output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output in_valid, in_addr, in_wdata, in_wen, in_size, in_unsigned,
      output out_ready, mem_rdata,
      input  in_ready, out_valid, out_rdata, out_fault,
      input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align
//    Combinational load-data aligner: shifts the addressed lane down to bit 0,
//    truncates to the access size and sign- or zero-extends.
//    rdata_i    : full memory word
//    offset_i   : byte offset within the word
//    size_i     : access size
//    unsigned_i : 1 = zero-extend, 0 = sign-extend
//    data_o     : extended result
module mem_lane_align
   import mau_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  size_t       size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      case (size_i)
         SZ_B:    data_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
         SZ_H:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//    Load/store initiator between the execute stage and the memory port.
//    Accepts one request in IDLE, checks alignment, issues exactly one
//    single-cycle memory access in ACCESS and holds the response in RESP.
//    clock   : system clock, rising edge
//    reset_n : asynchronous active-low reset
//    bus     : request / response / memory-port signals (slave side)
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic             clock,
   input  logic             reset_n,
   mem_access_unit_if.slave bus
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [1:0]      size_q, size_d;
   logic            wen_q, wen_d;
   logic            uns_q, uns_d;
   logic            fault_q, fault_d;

   logic            accept;
   logic [XLEN-1:0] lane_data;
   logic [3:0]      lane_mask;

   assign accept = (state_q == IDLE) && bus.in_valid;

   mem_lane_align u_lane_align (
      .rdata_i    (bus.mem_rdata),
      .offset_i   (addr_q[1:0]),
      .size_i     (size_t'(size_q)),
      .unsigned_i (uns_q),
      .data_o     (lane_data)
   );

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid)
                     state_d = misaligned(bus.in_size, bus.in_addr[1:0]) ? RESP : ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- request / response datapath ----------------
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      wen_d   = wen_q;
      uns_d   = uns_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = bus.in_addr;
         wdata_d = bus.in_wdata;
         size_d  = bus.in_size;
         wen_d   = bus.in_wen;
         uns_d   = bus.in_unsigned;
         fault_d = misaligned(bus.in_size, bus.in_addr[1:0]);
         rdata_d = '0;
      end else if (state_q == ACCESS) begin
         // The read word is captured on the same edge that ends the access.
         rdata_d = wen_q ? '0 : lane_data;
      end else if (state_q == RESP && bus.out_ready) begin
         fault_d = 1'b0;
         rdata_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         wen_q   <= 1'b0;
         uns_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         wen_q   <= wen_d;
         uns_q   <= uns_d;
         fault_q <= fault_d;
      end
   end

   // ---------------- output decode ----------------
   // Memory port is gated by the ACCESS state so exactly one strobe is
   // produced per request, and no input reaches it combinationally.
   always_comb begin
      lane_mask     = size_mask(size_t'(size_q)) << addr_q[1:0];
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == RESP);
      bus.out_fault = fault_q;
      bus.out_rdata = rdata_q;
      bus.mem_valid = 1'b0;
      bus.mem_wen   = 1'b0;
      bus.mem_raddr = '0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      if (state_q == ACCESS) begin
         bus.mem_valid = 1'b1;
         bus.mem_raddr = {addr_q[XLEN-1:2], 2'b00};
         bus.mem_waddr = {addr_q[XLEN-1:2], 2'b00};
         if (wen_q) begin
            bus.mem_wen   = 1'b1;
            bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
            bus.mem_wmask = {4'b0000, lane_mask};
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//    Self-checking bench: word-array memory device on the memory port, plus a
//    byte-level reference memory that predicts every response.
module tb_mem_access_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus ();

   mem_access_unit dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- memory device ----------------
   logic [31:0] mem [0:255];
   logic        mem_init = 1'b0;
   int          acc_cnt  = 0;

   function automatic logic [31:0] init_word(int i);
      if (i == 4) return 32'hDEAD_BEEF;
      if (i == 8) return 32'hA5A5_A5A5;
      return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   assign bus.mem_rdata = mem[bus.mem_raddr[9:2]];

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (bus.mem_valid) begin
         acc_cnt <= acc_cnt + 1;
         if (bus.mem_wen)
            for (int b = 0; b < 4; b++)
               if (bus.mem_wmask[b]) mem[bus.mem_waddr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [0:1023];

   task automatic model_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                            input logic [1:0] size, input logic uns,
                            output logic exp_fault, output logic [31:0] exp_rdata,
                            output logic [7:0] exp_wmask, output logic [31:0] exp_wdata);
      int nbytes;
      int off;
      logic [31:0] v;
      nbytes    = 1 << size;
      off       = int'(addr[1:0]);
      exp_fault = (size == 2'd3) || ((off % nbytes) != 0);
      exp_rdata = 32'h0;
      exp_wmask = 8'h00;
      exp_wdata = 32'h0;
      if (exp_fault) return;
      if (wen) begin
         for (int i = 0; i < nbytes; i++) ref_mem[(int'(addr[9:0]) + i)] = wdata[8*i +: 8];
         exp_wmask = 8'(((1 << nbytes) - 1) << off);
         exp_wdata = wdata << (8 * off);
      end else begin
         v = 32'h0;
         for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(addr[9:0]) + i]) << (8 * i));
         if (nbytes < 4 && !uns && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
         exp_rdata = v;
      end
   endtask

   // ---------------- transaction driver ----------------
   task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
                          input logic [1:0] size, input logic uns, input int hold,
                          output logic [31:0] rdata, output logic fault, output int lat,
                          output int nacc, output logic [31:0] raddr, output logic [31:0] waddr,
                          output logic [31:0] mwdata, output logic [7:0] wmask, output logic mwen);
      int acc0;
      @(negedge clk);
      bus.in_addr     = addr;
      bus.in_wdata    = wdata;
      bus.in_wen      = wen;
      bus.in_size     = size;
      bus.in_unsigned = uns;
      bus.in_valid    = 1'b1;
      bus.out_ready   = 1'b0;
      acc0 = acc_cnt;
      @(posedge clk);
      #1;
      // Scramble the payload: it must have been captured on the accept edge.
      bus.in_valid    = 1'b0;
      bus.in_addr     = $urandom;
      bus.in_wdata    = $urandom;
      bus.in_wen      = 1'($urandom);
      bus.in_size     = 2'($urandom);
      bus.in_unsigned = 1'($urandom);
      lat = 0; raddr = 0; waddr = 0; mwdata = 0; wmask = 0; mwen = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (bus.mem_valid) begin
            raddr = bus.mem_raddr; waddr = bus.mem_waddr; mwdata = bus.mem_wdata;
            wmask = bus.mem_wmask; mwen = bus.mem_wen;
         end
         if (bus.out_valid) break;
      end
      n_checks++;
      if (bus.out_valid !== 1'b1) begin
         $display("FAIL resp_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, lat);
         n_errors++;
      end
      rdata = bus.out_rdata;
      fault = bus.out_fault;
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      nacc = acc_cnt - acc0;
   endtask

   logic [31:0] g_rdata, g_raddr, g_waddr, g_wdata;
   logic [7:0]  g_wmask;
   logic        g_fault, g_wen;
   int          g_lat, g_nacc;
   logic        e_fault;
   logic [31:0] e_rdata, e_wdata;
   logic [7:0]  e_wmask;

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.in_valid = 0; bus.in_addr = 0; bus.in_wdata = 0; bus.in_wen = 0;
      bus.in_size = 0; bus.in_unsigned = 0; bus.out_ready = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); n_errors++; end
      n_checks++;
      if ({bus.out_valid, bus.out_fault, bus.out_rdata} !== 34'h0) begin
         $display("FAIL reset_out: valid=%b fault=%b rdata=%h want 0", bus.out_valid, bus.out_fault, bus.out_rdata);
         n_errors++;
      end
      n_checks++;
      if ({bus.mem_valid, bus.mem_wen, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask} !== 106'h0) begin
         $display("FAIL reset_mem: valid=%b wen=%b raddr=%h waddr=%h wdata=%h wmask=%h want 0",
                  bus.mem_valid, bus.mem_wen, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata, bus.mem_wmask);
         n_errors++;
      end
      rst_n = 1'b1;
   endtask

   task automatic check_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic wen, input logic [1:0] size, input logic uns, input int hold);
      model_req(addr, wdata, wen, size, uns, e_fault, e_rdata, e_wmask, e_wdata);
      run_req(addr, wdata, wen, size, uns, hold, g_rdata, g_fault, g_lat, g_nacc, g_raddr, g_waddr, g_wdata, g_wmask, g_wen);
      n_checks++;
      if (g_fault !== e_fault || g_rdata !== e_rdata) begin
         $display("FAIL %s_resp @%h: fault=%b rdata=%h want fault=%b rdata=%h", name, addr, g_fault, g_rdata, e_fault, e_rdata);
         n_errors++;
      end
      n_checks++;
      if (g_lat !== (e_fault ? 1 : 2) || g_nacc !== (e_fault ? 0 : 1)) begin
         $display("FAIL %s_timing @%h: latency=%0d accesses=%0d want %0d/%0d", name, addr, g_lat, g_nacc,
                  e_fault ? 1 : 2, e_fault ? 0 : 1);
         n_errors++;
      end
      if (!e_fault) begin
         n_checks++;
         if (g_raddr !== {addr[31:2], 2'b00} || g_waddr !== {addr[31:2], 2'b00} || g_wen !== wen ||
             g_wmask !== e_wmask || g_wdata !== e_wdata) begin
            $display("FAIL %s_memport @%h: raddr=%h waddr=%h wen=%b wmask=%h wdata=%h want addr=%h wen=%b wmask=%h wdata=%h",
                     name, addr, g_raddr, g_waddr, g_wen, g_wmask, g_wdata, {addr[31:2], 2'b00}, wen, e_wmask, e_wdata);
            n_errors++;
         end
      end
   endtask

   task automatic test_directed();
      check_txn("word_load",  32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 0);
      n_checks++;
      if (g_rdata !== 32'hDEAD_BEEF) begin $display("FAIL word_load_const: got %h want deadbeef", g_rdata); n_errors++; end
      check_txn("sbyte_load", 32'h8000_0013, 32'h0, 1'b0, 2'd0, 1'b0, 1);
      n_checks++;
      if (g_rdata !== 32'hFFFF_FFDE) begin $display("FAIL sbyte_const: got %h want ffffffde", g_rdata); n_errors++; end
      check_txn("ubyte_load", 32'h8000_0013, 32'h0, 1'b0, 2'd0, 1'b1, 0);
      n_checks++;
      if (g_rdata !== 32'h0000_00DE) begin $display("FAIL ubyte_const: got %h want 000000de", g_rdata); n_errors++; end
      check_txn("uhalf_load", 32'h8000_0012, 32'h0, 1'b0, 2'd1, 1'b1, 0);
      n_checks++;
      if (g_rdata !== 32'h0000_DEAD) begin $display("FAIL uhalf_const: got %h want 0000dead", g_rdata); n_errors++; end
      check_txn("half_store", 32'h8000_0022, 32'h0000_1234, 1'b1, 2'd1, 1'b0, 0);
      n_checks++;
      if (g_waddr !== 32'h8000_0020 || g_wdata !== 32'h1234_0000 || g_wmask !== 8'h0C) begin
         $display("FAIL half_store_const: waddr=%h wdata=%h wmask=%h want 80000020/12340000/0c", g_waddr, g_wdata, g_wmask);
         n_errors++;
      end
      check_txn("merged_load", 32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0, 0);
      n_checks++;
      if (g_rdata !== 32'h1234_A5A5) begin $display("FAIL merged_const: got %h want 1234a5a5", g_rdata); n_errors++; end
   endtask

   task automatic test_faults();
      check_txn("fault_word", 32'h8000_0001, 32'h0,         1'b0, 2'd2, 1'b0, 0);
      check_txn("fault_half", 32'h8000_0003, 32'hCAFE_F00D, 1'b1, 2'd1, 1'b0, 0);
      check_txn("fault_size", 32'h8000_0000, 32'hCAFE_F00D, 1'b1, 2'd3, 1'b0, 2);
      n_checks++;
      if (g_fault !== 1'b1 || g_rdata !== 32'h0) begin
         $display("FAIL fault_size_const: fault=%b rdata=%h want 1/0", g_fault, g_rdata); n_errors++;
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      @(negedge clk);
      bus.in_addr = 32'h8000_0010; bus.in_wdata = 0; bus.in_wen = 0; bus.in_size = 2'd2;
      bus.in_unsigned = 0; bus.in_valid = 1; bus.out_ready = 0;
      @(posedge clk);
      #1;
      // Second request held pending while the first is outstanding.
      bus.in_addr = 32'h8000_0011; bus.in_size = 2'd0; bus.in_unsigned = 1;
      cyc = 0;
      while (cyc < 8 && bus.out_valid !== 1'b1) begin @(negedge clk); cyc++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_rdata !== 32'hDEAD_BEEF || bus.in_ready !== 1'b0 || bus.mem_valid !== 1'b0) begin
            $display("FAIL bp_hold[%0d]: valid=%b rdata=%h in_ready=%b mem_valid=%b want 1/deadbeef/0/0",
                     i, bus.out_valid, bus.out_rdata, bus.in_ready, bus.mem_valid);
            n_errors++;
         end
         @(negedge clk);
      end
      bus.out_ready = 1;
      @(posedge clk);
      #1;
      bus.out_ready = 0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_rdata !== 32'h0 || bus.in_ready !== 1'b1) begin
         $display("FAIL bp_release: valid=%b rdata=%h in_ready=%b want 0/0/1", bus.out_valid, bus.out_rdata, bus.in_ready);
         n_errors++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 0;
      n_checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_raddr !== 32'h8000_0010 || bus.in_ready !== 1'b0) begin
         $display("FAIL bp_next_accept: mem_valid=%b raddr=%h in_ready=%b want 1/80000010/0", bus.mem_valid, bus.mem_raddr, bus.in_ready);
         n_errors++;
      end
      cyc = 0;
      while (cyc < 8 && bus.out_valid !== 1'b1) begin @(negedge clk); cyc++; end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_rdata !== 32'h0000_00BE) begin
         $display("FAIL bp_second_resp: valid=%b rdata=%h want 1/000000be", bus.out_valid, bus.out_rdata); n_errors++;
      end
      bus.out_ready = 1;
      @(posedge clk);
      #1;
      bus.out_ready = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.in_addr = 32'h8000_0010; bus.in_wdata = 0; bus.in_wen = 0; bus.in_size = 2'd2;
      bus.in_unsigned = 0; bus.in_valid = 1;
      @(posedge clk);
      #1;
      bus.in_valid = 0;
      n_checks++;
      if (bus.mem_valid !== 1'b1) begin $display("FAIL rst_mid_access: mem_valid=%b want 1", bus.mem_valid); n_errors++; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         $display("FAIL rst_mid_async: mem_valid=%b out_valid=%b in_ready=%b want 0/0/1", bus.mem_valid, bus.out_valid, bus.in_ready);
         n_errors++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         $display("FAIL rst_mid_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); n_errors++;
      end
      check_txn("post_reset_load", 32'h8000_0012, 32'h0, 1'b0, 2'd1, 1'b0, 0);
      n_checks++;
      if (g_rdata !== 32'hFFFF_DEAD) begin $display("FAIL post_reset_const: got %h want ffffdead", g_rdata); n_errors++; end
   endtask

   task automatic test_random();
      logic [31:0] a, w;
      for (int i = 0; i < 150; i++) begin
         a = 32'h8000_0000 | 32'($urandom_range(0, 1023));
         w = $urandom;
         check_txn("rand", a, w, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2));
      end
   endtask

   task automatic test_mem_contents();
      logic [31:0] exp;
      @(negedge clk);
      for (int w = 0; w < 256; w++) begin
         exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
         n_checks++;
         if (mem[w] !== exp) begin $display("FAIL mem_word[%0d]: got %h want %h", w, mem[w], exp); n_errors++; end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(init_word(i) >> (8 * b));
      test_reset();
      test_directed();
      test_faults();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_mem_contents();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the execute stage and the DPI-backed `MemContrl` memory port. It accepts one load or store per request handshake and checks alignment. It issues exactly one single-cycle memory access with word-aligned address, lane-shifted data and byte mask. It returns the aligned, sign- or zero-extended load result, or a store completion, on a registered valid/ready response channel.

## Interface
- `XLEN`, 32, data and address width; only 32 is supported.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when high with `in_valid`.
- `in_addr`  in  32  byte address.
- `in_wdata`  in  32  store data, right-justified.
- `in_wen`  in  1  1 = store, 0 = load.
- `in_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises a fault.
- `in_unsigned`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  response consumed.
- `out_rdata`  out  32  extended load data; 0 for stores and faults.
- `out_fault`  out  1  misaligned address or illegal size.
- `mem_valid`  out  1  memory access strobe.
- `mem_raddr`  out  32  word-aligned read address.
- `mem_wen`  out  1  write enable.
- `mem_waddr`  out  32  word-aligned write address.
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_wmask`  out  8  byte mask; bits [7:4] are always 0.
- `mem_rdata`  in  32  read data, valid combinationally in the same cycle as `mem_valid`.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **Reset:** state is IDLE and all registers are cleared.
  - `in_ready` = 1.
  - `out_valid`, `out_fault`, `out_rdata` = 0.
  - All `mem_*` outputs = 0.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid`, latch `addr`, `wdata`, `wen`, `size` and `unsigned`.
  - Fault condition: `size` == 3, or (`size` == 1 and `addr[0]`), or (`size` == 2 and `addr[1:0]` != 0).
  - Fault → RESP with `out_fault` = 1. No memory access is issued.
  - Otherwise → ACCESS.
- **ACCESS** (exactly one cycle):
  - `mem_valid` = 1.
  - `mem_raddr` = `mem_waddr` = {`addr[31:2]`, 2'b00}.
  - Store: `mem_wen` = 1, `mem_wdata` = `wdata` << (8·`addr[1:0]`), `mem_wmask` = base mask << `addr[1:0]`, where the base mask is 0x1, 0x3 or 0xF for byte, half or word.
  - Load: `mem_wen` = 0, `mem_wmask` = 0, `mem_wdata` = 0.
  - `mem_rdata` is sampled at the end of the cycle.
  - Lane extraction is `mem_rdata` >> (8·`addr[1:0]`), truncated to the access size, then extended per `unsigned`.
  - The extended value is registered into `out_rdata` (loads only; stores register 0).
  - → RESP.
- **RESP:**
  - `out_valid` = 1; `out_rdata` and `out_fault` are held stable.
  - On `out_ready` → IDLE, and `out_valid`, `out_fault`, `out_rdata` clear on that edge.
  - `in_ready` = 0, so a new request is accepted only in IDLE (the cycle after the response handshake).
- **Outside ACCESS:** `mem_valid` and all other `mem_*` outputs are driven 0, which guarantees one DPI read/write per request.
- **Reset during operation:**
  - During ACCESS, `mem_valid` drops immediately. Whether the store already took effect is undefined, and no retry is performed.
  - During RESP, the response is discarded.
- **Handshake rules:**
  - Request payload is only sampled on the `in_valid && in_ready` edge; changes afterwards are ignored.
  - `out_ready` held high permanently is legal.

## Timing
- Request accepted at edge N.
- `mem_valid` is high during cycle N..N+1.
- `out_valid` rises after edge N+1.
- Minimum latency: 2 cycles from accept to `out_valid`; 1 cycle for faults.
- Back-to-back throughput: one request per 3 cycles (accept, ACCESS, RESP with immediate `out_ready`).
- All outputs are driven from registers or the state decode; there is no combinational path from `in_*` to `mem_*`.
- `mem_rdata` → `out_rdata` register is the only combinational path through the block.

## Structure
- **Package `mau_pkg`:**
  - `state_t` enum: IDLE, ACCESS, RESP.
  - `size_t` enum: SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - Function `size_mask(size_t)` returning 4 bits.
  - Function `misaligned(size, addr[1:0])`.
- **Sub-module `mem_lane_align`:** purely combinational. Inputs are `rdata`, `offset[1:0]`, `size`, `unsigned`; output is the 32-bit extended value. It is instantiated once, on the ACCESS-cycle read path.

## Test plan
- **Word load:** memory holds 0xDEADBEEF at 0x80000010; load word at 0x80000010 → `mem_raddr` 0x80000010, `mem_wmask` 0, `out_rdata` 0xDEADBEEF, `out_fault` 0, `out_valid` two cycles after accept.
- **Signed vs unsigned byte load:** same word; signed byte load at 0x80000013 → `out_rdata` 0xFFFFFFDE; unsigned → 0x000000DE; unsigned half at 0x80000012 → 0x0000DEAD.
- **Half store:** store half 0x1234 at 0x80000022 → exactly one `mem_valid` cycle with `mem_waddr` 0x80000020, `mem_wdata` 0x12340000, `mem_wmask` 0x0C; a subsequent word read returns the merged value.
- **Misaligned and illegal:** word load at 0x80000001, half store at 0x80000003, and `in_size` = 3 → `mem_valid` never asserts, `out_fault` 1, `out_rdata` 0, response after 1 cycle.
- **Backpressure:** `out_ready` held 0 for 5 cycles → `out_valid`/`out_rdata` stable, `in_ready` 0 throughout, `mem_valid` stays 0; `in_valid` held high is accepted the cycle after `out_ready` rises.
- **Reset:** assert `reset_n` = 0 mid-ACCESS → `mem_valid`, `out_valid` drop asynchronously, state IDLE, `in_ready` 1 on release; the next load completes normally.
